imem_loader: RTL

Boot-time instruction-memory writer for the single-cycle MIPS CPU. It accepts a byte stream over a valid/ready handshake, packs the bytes into big-endian 32-bit words, and writes them into the instruction memory's write port. It holds the CPU in reset until the whole image is written, then releases it. It is the writer counterpart of the CPU's instruction fetch, and it replaces the bench-driven reset release.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_word_packer.sv | 33 +++
 rtl/imem_loader.sv | 112 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package cpu_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } loaderState_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port and CPU release out.
interface imem_loader_if #(parameter int ADDR_W = 8) ();

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              err;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, err
    );

endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word.
// Latency: word updates at the accepting edge; wordFull flags the 4th byte combinationally.
// Backpressure: none of its own; shifts only when accept is high.
module imem_word_packer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  dataByte,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        wordFull
);

    logic [1:0] byteCnt;

    assign wordFull = accept && (byteCnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word    <= '0;
            byteCnt <= '0;
        end else if (clear) begin
            word    <= '0;
            byteCnt <= '0;
        end else if (accept) begin
            word    <= {word[23:0], dataByte};
            byteCnt <= byteCnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian image into instruction memory, then releases the CPU.
// Latency: one WRITE cycle after each 4th byte; done/cpu_reset rise on the edge ending the last write.
// Backpressure: rx_ready low during WRITE, DONE and ERR; the sender holds its byte.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    localparam int MAX_WORDS = 2 ** ADDR_W;

    loaderState_e      state;
    logic [7:0]        lenHi;
    logic [LEN_W-1:0]  nWords;
    logic [LEN_W-1:0]  lenWord;
    logic [ADDR_W:0]   wordCnt;
    logic              imemWe;
    logic [ADDR_W-1:0] imemAddr;
    logic              cpuReset;
    logic              doneR;
    logic              errR;
    logic              accept;
    logic [31:0]       packedWord;
    logic              wordFull;

    // Gated by reset so the sender never sees ready while the loader is held.
    assign bus.rx_ready = reset && (state == LEN_HI || state == LEN_LO || state == DATA);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign lenWord      = {lenHi, bus.rx_data};

    assign bus.imem_we    = imemWe;
    assign bus.imem_addr  = imemAddr;
    assign bus.imem_wdata = packedWord;
    assign bus.cpu_reset  = cpuReset;
    assign bus.done       = doneR;
    assign bus.err        = errR;

    imem_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .dataByte (bus.rx_data),
        .accept   (accept && state == DATA),
        .clear    (accept && state == LEN_LO),
        .word     (packedWord),
        .wordFull (wordFull)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= LEN_HI;
            lenHi    <= '0;
            nWords   <= '0;
            wordCnt  <= '0;
            imemWe   <= 1'b0;
            imemAddr <= '0;
            cpuReset <= 1'b0;
            doneR    <= 1'b0;
            errR     <= 1'b0;
        end else begin
            case (state)
                LEN_HI: begin
                    if (accept) begin
                        lenHi <= bus.rx_data;
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        nWords  <= lenWord;
                        wordCnt <= '0;
                        if (lenWord == '0) begin
                            state    <= DONE;
                            doneR    <= 1'b1;
                            cpuReset <= 1'b1;
                        end else if (lenWord > LEN_W'(MAX_WORDS)) begin
                            state <= ERR;
                            errR  <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (wordFull) begin
                        state    <= WRITE;
                        imemWe   <= 1'b1;
                        imemAddr <= wordCnt[ADDR_W-1:0];
                    end
                end
                WRITE: begin
                    imemWe  <= 1'b0;
                    wordCnt <= wordCnt + 1'b1;
                    if (LEN_W'(wordCnt) == nWords - LEN_W'(1)) begin
                        state    <= DONE;
                        doneR    <= 1'b1;
                        cpuReset <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DONE:    state <= DONE;
                ERR:     state <= ERR;
                default: state <= LEN_HI;
            endcase
        end
    end

endmodule
